// File: rtl/lcb_pkg.sv
// Shared types and constants for the LCB reply framer.
package lcb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT1,
    COLLECT,
    RELEASE,
    FILLOUT
  } lcb_state_e;

  localparam logic [7:0] FILL_DEFAULT = 8'h00;
  localparam int         TIMER_W      = 13;
  localparam int         ADDR_W       = 5;

endpackage

// File: rtl/lcb_reply_buf.sv
// 32x8 simple dual-port reply buffer with a registered read port, written
// so synthesis maps it onto block RAM.
module lcb_reply_buf
  import lcb_pkg::*;
(
  input  logic              clk,
  input  logic              wrEn_i,
  input  logic [ADDR_W-1:0] wrAddr_i,
  input  logic [7:0]        wrData_i,
  input  logic              rdEn_i,
  input  logic [ADDR_W-1:0] rdAddr_i,
  output logic [7:0]        rdData_o
);

  logic [7:0] mem_q [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (wrEn_i) mem_q[wrAddr_i] <= wrData_i;
    if (rdEn_i) rdData_o <= mem_q[rdAddr_i];
  end

endmodule

// File: rtl/lcb_reply_framer.sv
// Buffers one LCB reply, then releases exactly BYTES bytes (or a fill frame
// on a missing/short/stalled reply) at one byte every two clocks.
module lcb_reply_framer
  import lcb_pkg::*;
#(
  parameter int         BYTES   = 16,
  parameter int         GAP_TO  = 400,
  parameter int         RESP_TO = 4000,
  parameter logic [7:0] FILL    = FILL_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iStart,
  input  logic [7:0] iData,
  input  logic       iValid,
  output logic [7:0] oData,
  output logic       oValid,
  output logic       oFrameOk,
  output logic       oFrameErr,
  output logic       oOverrun,
  output logic [7:0] oErrCnt
);

  localparam logic [ADDR_W-1:0]  LAST_PTR = ADDR_W'(BYTES - 1);
  localparam logic [TIMER_W-1:0] RESP_LIM = TIMER_W'(RESP_TO);
  localparam logic [TIMER_W-1:0] GAP_LIM  = TIMER_W'(GAP_TO);
  localparam logic [5:0]         RD_END   = 6'(2 * BYTES);
  localparam logic [5:0]         CNT_DONE = 6'(2 * BYTES + 1);

  lcb_state_e         state_q, state_d;
  logic [ADDR_W-1:0]  wptr_q, wptr_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [5:0]         cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic               rdValid_q, rdValid_d;
  logic               rdFill_q, rdFill_d;
  logic [7:0]         oData_q, oData_d;
  logic               oValid_q;
  logic               ok_q, ok_d;
  logic               err_q, err_d;
  logic               overrun_q, overrun_d;
  logic [7:0]         errCnt_q, errCnt_d;

  logic               wrEn;
  logic               rdEn;
  logic [7:0]         rdData;

  lcb_reply_buf u_buf (
    .clk      (clk),
    .wrEn_i   (wrEn),
    .wrAddr_i (wptr_q),
    .wrData_i (iData),
    .rdEn_i   (rdEn),
    .rdAddr_i (cnt_q[5:1]),
    .rdData_o (rdData)
  );

  // During RELEASE/FILLOUT, cnt_q paces the frame: even counts issue a byte,
  // and the two-stage read/output pipeline puts the frame pulse at CNT_DONE.
  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    timer_d   = timer_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    rdValid_d = 1'b0;
    rdFill_d  = 1'b0;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    overrun_d = overrun_q;
    errCnt_d  = errCnt_q;
    wrEn      = 1'b0;
    rdEn      = 1'b0;

    if ((state_q == WAIT1 || state_q == COLLECT) && timer_q != '1)
      timer_d = timer_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (iValid) overrun_d = 1'b1;
        if (iStart || pend_q) begin
          state_d = WAIT1;
          pend_d  = 1'b0;
          wptr_d  = '0;
          timer_d = '0;
        end
      end
      WAIT1: begin
        if (iStart) pend_d = 1'b1;
        if (iValid) begin
          wrEn    = 1'b1;
          wptr_d  = ADDR_W'(1);
          timer_d = '0;
          cnt_d   = '0;
          state_d = (BYTES == 1) ? RELEASE : COLLECT;
        end else if (timer_q == RESP_LIM) begin
          cnt_d   = '0;
          state_d = FILLOUT;
        end
      end
      COLLECT: begin
        if (iStart) pend_d = 1'b1;
        if (iValid) begin
          wrEn    = 1'b1;
          wptr_d  = wptr_q + 1'b1;
          timer_d = '0;
          if (wptr_q == LAST_PTR) begin
            cnt_d   = '0;
            state_d = RELEASE;
          end
        end else if (timer_q == GAP_LIM) begin
          cnt_d   = '0;
          state_d = FILLOUT;
        end
      end
      RELEASE, FILLOUT: begin
        if (iStart) pend_d = 1'b1;
        if (iValid) overrun_d = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (!cnt_q[0] && cnt_q < RD_END) begin
          rdValid_d = 1'b1;
          rdFill_d  = (state_q == FILLOUT);
          rdEn      = (state_q == RELEASE);
        end
        if (cnt_q == CNT_DONE) begin
          state_d = IDLE;
          if (state_q == RELEASE) begin
            ok_d = 1'b1;
          end else begin
            err_d = 1'b1;
            if (errCnt_q != 8'hFF) errCnt_d = errCnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    oData_d = oData_q;
    if (rdValid_q) oData_d = rdFill_q ? FILL : rdData;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      timer_q   <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      rdValid_q <= 1'b0;
      rdFill_q  <= 1'b0;
      oData_q   <= '0;
      oValid_q  <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
      errCnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      timer_q   <= timer_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      rdValid_q <= rdValid_d;
      rdFill_q  <= rdFill_d;
      oData_q   <= oData_d;
      oValid_q  <= rdValid_q;
      ok_q      <= ok_d;
      err_q     <= err_d;
      overrun_q <= overrun_d;
      errCnt_q  <= errCnt_d;
    end
  end

  assign oData     = oData_q;
  assign oValid    = oValid_q;
  assign oFrameOk  = ok_q;
  assign oFrameErr = err_q;
  assign oOverrun  = overrun_q;
  assign oErrCnt   = errCnt_q;

endmodule

// File: tb/tb_lcb_reply_framer.sv
// Self-checking bench for lcb_reply_framer: frames are scored against a
// timestamp-level model of reply acceptance, timeouts and release timing.
module tb_lcb_reply_framer;
  import lcb_pkg::*;

  localparam int         BYTES   = 16;
  localparam int         GAP_TO  = 400;
  localparam int         RESP_TO = 4000;
  localparam logic [7:0] FILL    = 8'h00;

  logic       clk = 1'b0;
  logic       rst;
  logic       iStart;
  logic [7:0] iData;
  logic       iValid;
  logic [7:0] oData;
  logic       oValid;
  logic       oFrameOk;
  logic       oFrameErr;
  logic       oOverrun;
  logic [7:0] oErrCnt;

  lcb_reply_framer #(
    .BYTES   (BYTES),
    .GAP_TO  (GAP_TO),
    .RESP_TO (RESP_TO),
    .FILL    (FILL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .iStart    (iStart),
    .iData     (iData),
    .iValid    (iValid),
    .oData     (oData),
    .oValid    (oValid),
    .oFrameOk  (oFrameOk),
    .oFrameErr (oFrameErr),
    .oOverrun  (oOverrun),
    .oErrCnt   (oErrCnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         nCompared = 0;
  int         nMismatch = 0;
  int         expErrCnt = 0;
  bit         expOverrun = 1'b0;

  int         sentT[$];
  logic [7:0] sentD[$];
  int         outT[$];
  logic [7:0] outD[$];
  int         okT[$];
  int         errT[$];

  // Capture every strobe with the index of the clock edge that produced it.
  always @(negedge clk) begin
    if (!rst) begin
      if (oValid) begin
        outT.push_back(cyc);
        outD.push_back(oData);
      end
      if (oFrameOk)  okT.push_back(cyc);
      if (oFrameErr) errT.push_back(cyc);
    end
  end

  task automatic clearAll();
    outT.delete(); outD.delete(); okT.delete(); errT.delete();
    sentT.delete(); sentD.delete();
  endtask

  task automatic pulseStart(output int t);
    @(negedge clk);
    iStart = 1'b1;
    t = cyc + 1;
    @(posedge clk);
    #1 iStart = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] d, input int gap);
    repeat (gap) @(negedge clk);
    iValid = 1'b1;
    iData  = d;
    sentT.push_back(cyc + 1);
    sentD.push_back(d);
    @(posedge clk);
    #1 iValid = 1'b0;
  endtask

  // Model: a byte is accepted while it arrives no later than limit+1 edges
  // after the previous event (start or byte); otherwise the timeout fires at
  // last+limit+1. Output bytes follow 2 edges after the deciding edge, every
  // 2 edges, and the frame pulse 2 edges after the last byte.
  task automatic checkFrame(input string name, input int s, output int endT);
    int         last, limit, lastAcc, tOut, base, guard, pt;
    logic [7:0] acc[$];
    logic [7:0] expD[$];
    bit         good;
    last = s; limit = RESP_TO; lastAcc = -1; tOut = -1;
    foreach (sentT[i]) begin
      if (lastAcc >= 0 || tOut >= 0) begin
        expOverrun = 1'b1;
      end else if (sentT[i] - last > limit + 1) begin
        tOut = last + limit + 1;
        expOverrun = 1'b1;
      end else begin
        acc.push_back(sentD[i]);
        last  = sentT[i];
        limit = GAP_TO;
        if (acc.size() == BYTES) lastAcc = sentT[i];
      end
    end
    if (lastAcc < 0 && tOut < 0) tOut = last + limit + 1;
    good = (lastAcc >= 0);
    base = good ? lastAcc : tOut;
    for (int i = 0; i < BYTES; i++) expD.push_back(good ? acc[i] : FILL);
    endT = base + 2 * BYTES + 2;
    if (!good && expErrCnt < 255) expErrCnt++;

    guard = 0;
    while (cyc < endT + 2 && guard < 40000) begin
      @(negedge clk);
      guard++;
    end

    nCompared++;
    if (outD.size() != BYTES) begin
      nMismatch++;
      $display("[TB] FAIL %s byteCount: got %0d expected %0d", name, outD.size(), BYTES);
    end
    for (int i = 0; i < BYTES && i < outD.size(); i++) begin
      nCompared++;
      if (outD[i] !== expD[i]) begin
        nMismatch++;
        $display("[TB] FAIL %s data[%0d]: got %02h expected %02h", name, i, outD[i], expD[i]);
      end
      nCompared++;
      if (outT[i] != base + 2 + 2 * i) begin
        nMismatch++;
        $display("[TB] FAIL %s time[%0d]: got %0d expected %0d", name, i, outT[i], base + 2 + 2 * i);
      end
    end
    nCompared++;
    if (okT.size() != (good ? 1 : 0) || errT.size() != (good ? 0 : 1)) begin
      nMismatch++;
      $display("[TB] FAIL %s pulses: got ok=%0d err=%0d expected ok=%0d err=%0d",
               name, okT.size(), errT.size(), good ? 1 : 0, good ? 0 : 1);
    end else begin
      pt = good ? okT[0] : errT[0];
      nCompared++;
      if (pt != endT) begin
        nMismatch++;
        $display("[TB] FAIL %s pulseTime: got %0d expected %0d", name, pt, endT);
      end
    end
    nCompared++;
    if (oErrCnt !== 8'(expErrCnt)) begin
      nMismatch++;
      $display("[TB] FAIL %s errCnt: got %0d expected %0d", name, oErrCnt, expErrCnt);
    end
    nCompared++;
    if (oOverrun !== expOverrun) begin
      nMismatch++;
      $display("[TB] FAIL %s overrun: got %0b expected %0b", name, oOverrun, expOverrun);
    end
    clearAll();
  endtask

  task automatic checkResetOutputs(input string name);
    logic [12:0] got;
    got = {oData, oValid, oFrameOk, oFrameErr, oOverrun};
    nCompared++;
    if (got !== 13'h0) begin
      nMismatch++;
      $display("[TB] FAIL %s outputs: got %04h expected 0000", name, got);
    end
    nCompared++;
    if (oErrCnt !== 8'h00) begin
      nMismatch++;
      $display("[TB] FAIL %s errCnt: got %0d expected 0", name, oErrCnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; iStart = 1'b0; iValid = 1'b0; iData = 8'h00;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    clearAll();
  endtask

  task automatic test_good_frame();
    int s, e;
    pulseStart(s);
    for (int i = 0; i < BYTES; i++) sendByte(8'(i + 1), 167);
    checkFrame("good", s, e);
  endtask

  task automatic test_no_reply();
    int s, e;
    pulseStart(s);
    checkFrame("noReply", s, e);
  endtask

  task automatic test_short_reply();
    int s, e;
    pulseStart(s);
    for (int i = 0; i < 10; i++) sendByte(8'(8'h50 + i), 167);
    checkFrame("short", s, e);
  endtask

  task automatic test_overrun();
    int s, e;
    pulseStart(s);
    for (int i = 0; i < BYTES + 2; i++) sendByte(8'(8'h20 + i), 167);
    checkFrame("overrun", s, e);
  endtask

  task automatic test_start_in_release();
    int s, e, dummy;
    pulseStart(s);
    for (int i = 0; i < BYTES; i++) sendByte(8'($urandom), 167);
    repeat (4) @(negedge clk);
    pulseStart(dummy);
    checkFrame("relFrame1", s, e);
    for (int i = 0; i < BYTES; i++) sendByte(8'(8'hA0 + i), $urandom_range(1, 300));
    checkFrame("relFrame2", e + 1, dummy);
  endtask

  task automatic test_reset_mid_collect();
    int s, e;
    pulseStart(s);
    for (int i = 0; i < 7; i++) sendByte(8'(8'h70 + i), 50);
    #3 rst = 1'b1;
    #2 checkResetOutputs("midReset");
    repeat (2) @(negedge clk);
    checkResetOutputs("midResetHeld");
    rst = 1'b0;
    expErrCnt = 0;
    expOverrun = 1'b0;
    clearAll();
    repeat (60) @(negedge clk);
    nCompared++;
    if (outD.size() != 0 || okT.size() != 0 || errT.size() != 0) begin
      nMismatch++;
      $display("[TB] FAIL midReset partialOutput: got %0d bytes expected 0", outD.size());
    end
    clearAll();
    pulseStart(s);
    for (int i = 0; i < BYTES; i++) sendByte(8'($urandom), 167);
    checkFrame("afterReset", s, e);
  endtask

  task automatic test_boundary_timing();
    int s, e;
    pulseStart(s);
    sendByte(8'hC0, RESP_TO);
    for (int i = 1; i < BYTES; i++) sendByte(8'(8'hC0 + i), GAP_TO);
    checkFrame("boundary", s, e);
  endtask

  task automatic test_random();
    int s, e, nb;
    for (int f = 0; f < 4; f++) begin
      nb = ($urandom_range(0, 1) == 1) ? BYTES : $urandom_range(1, BYTES);
      pulseStart(s);
      for (int i = 0; i < nb; i++)
        sendByte(8'($urandom), (i == 0) ? $urandom_range(1, 300) : $urandom_range(1, GAP_TO - 20));
      checkFrame("random", s, e);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_no_reply();
    test_short_reply();
    test_overrun();
    test_start_in_release();
    test_reset_mid_collect();
    test_boundary_timing();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/lcb_reply_framer.md
# lcb_reply_framer

Sits between `uartRx` and `writer` on each LCB channel. Collects the bytes of one LCB reply into a local buffer and checks the byte count. Then releases exactly `BYTES` bytes downstream per request cycle. A missing, short or stalled reply is replaced by a fill frame, so the orbit word layout built by the packer never slips.

## Interface
Parameters:
- `BYTES`, 16, reply length in bytes (1..31)
- `GAP_TO`, 400, max clocks between consecutive reply bytes
- `RESP_TO`, 4000, max clocks from `iStart` to the first reply byte
- `FILL`, 8'h00, substitute byte value

Ports:
- `clk`  in  1  80 MHz system clock
- `rst`  in  1  asynchronous, active-high reset
- `iStart`  in  1  one-clock pulse when the request transmission completes (TX `full`)
- `iData`  in  8  received byte
- `iValid`  in  1  one-clock strobe qualifying `iData`
- `oData`  out  8  byte to `writer`
- `oValid`  out  1  one-clock strobe qualifying `oData`
- `oFrameOk`  out  1  one-clock pulse after the last byte of a good frame is released
- `oFrameErr`  out  1  one-clock pulse after the last byte of a fill frame is released
- `oOverrun`  out  1  sticky; set when bytes are dropped; cleared by `rst` only
- `oErrCnt`  out  8  saturating count of fill frames

## Operation
- States: `IDLE`, `WAIT1`, `COLLECT`, `RELEASE`, `FILLOUT`.
- `IDLE`:
  - `iStart` clears the write pointer and timer, then goes to `WAIT1`.
  - `iValid` in this state drops the byte and sets `oOverrun`.
- `WAIT1`:
  - `iValid` writes byte 0, sets wptr=1, resets the timer, then goes to `COLLECT`.
  - Timer reaching `RESP_TO` goes to `FILLOUT`.
- `COLLECT`:
  - Each `iValid` writes `buf[wptr]`, increments wptr and resets the timer.
  - When wptr reaches `BYTES` (on the write of the last byte), go to `RELEASE`.
  - Timer reaching `GAP_TO` with wptr<`BYTES` goes to `FILLOUT`; the partial data is discarded.
- `RELEASE`:
  - Outputs `buf[0..BYTES-1]` in order, one byte every 2 clocks (`oValid` high 1 clock, low 1 clock).
  - After the last byte, pulses `oFrameOk` and returns to `IDLE`.
- `FILLOUT`:
  - Same cadence as `RELEASE`, emitting `BYTES` copies of `FILL`.
  - Then pulses `oFrameErr`, increments `oErrCnt` (saturates at 255) and returns to `IDLE`.
- Bytes arriving in `RELEASE`/`FILLOUT` are dropped and set `oOverrun`.
- `iStart` arriving in `WAIT1`/`COLLECT`/`RELEASE`/`FILLOUT` is held in a single pending flag:
  - Serviced on the return to `IDLE` (enter `WAIT1` the next clock).
  - A second `iStart` while the flag is set is merged into it.
  - In `WAIT1`/`COLLECT` it does not abort the current frame.
- `iStart` and `iValid` in the same `IDLE` clock: the start is taken and the byte is dropped (`oOverrun` set).
- Timer: 13-bit, saturating, active only in `WAIT1`/`COLLECT`.

## Timing
- Reset values: `oData`=0, `oValid`=0, `oFrameOk`=0, `oFrameErr`=0, `oOverrun`=0, `oErrCnt`=0; state `IDLE`; pending flag cleared.
- Reset mid-frame aborts immediately with no partial output.
- All outputs are registered.
- First `oValid` comes 2 clocks after the clock that writes the last byte (buffer read latency 1, plus 1 for the output register).
- Frame output duration is 2·`BYTES` clocks.
- `oFrameOk`/`oFrameErr` assert 2 clocks after the last `oValid`.
- Timeout is detected on the clock the timer equals the limit; `FILLOUT`'s first `oValid` follows 2 clocks later.

## Structure
- Package `lcb_pkg`:
  - State enum.
  - `FILL_DEFAULT`.
  - `TIMER_W`=13.
- Sub-module `lcb_reply_buf`: a 32×8 simple dual-port RAM with synchronous read, one write port and one read port. It infers block RAM, or uses `ramUART` directly.

## Test plan
- Good frame: `iStart`, then 16 bytes 0x01..0x10 spaced 167 clocks → `oData` 0x01..0x10 every 2 clocks, then `oFrameOk`; `oErrCnt`=0.
- No reply: `iStart` with no bytes → after 4000 clocks, 16×0x00 on `oData`, then `oFrameErr`; `oErrCnt`=1.
- Short reply: 10 bytes, then silence → 400 clocks after byte 10, 16 fill bytes and `oFrameErr`; none of the partial data appears.
- Overrun: 18 bytes sent back-to-back at 167-clock spacing → 16 released; bytes 17 and 18 set `oOverrun`; `oFrameOk` pulses once.
- `iStart` during `RELEASE`: frame completes normally, then the state is `WAIT1` one clock after `IDLE`; a second frame of 0xA0..0xAF is released correctly.
- Async reset asserted mid-`COLLECT` (byte 7) → all outputs 0 within the reset; a following `iStart` plus 16 bytes yields a clean `oFrameOk`.
